instr_reg: RTL

Instruction register and fetch tracker for the 8-bit multicycle MIPS core. It captures the four instruction bytes that memory returns during the four fetch states, under control of the controller's one-hot `irwrite[3:0]`. It drives `op`/`funct` back into the controller and the register/immediate fields into the datapath. It also reports fetch completeness, fetch-sequence errors and a retired-fetch count.

---
 rtl/mips8_pkg.sv | 41 ++++
 rtl/ir_lane.sv | 30 +++
 rtl/instr_reg.sv | 110 +++++++++++
 3 files changed

// File: rtl/mips8_pkg.sv
// ============================================================================
// Module      : mips8_pkg
// Description : Shared instruction-field positions, fetch tracker states and
//               the byte-lane mapping used by the 8-bit multicycle MIPS core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips8_pkg;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    localparam int NLANES   = 4;

    // Next lane the fetch tracker expects to see written.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L1   = 2'd1,
        L2   = 2'd2,
        L3   = 2'd3
    } fetch_state_t;

    // Big-endian fetch order: lane 0 carries the opcode byte at [31:24].
    function automatic int lane_lo(input int lane);
        return 24 - 8 * lane;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ir_lane.sv
// ============================================================================
// Module      : ir_lane
// Description : One 8-bit byte lane of the instruction register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_lane (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] d,
    output logic [7:0] q
);

    logic [7:0] r_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= 8'h00;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/instr_reg.sv
// ============================================================================
// Module      : instr_reg
// Description : Instruction register with fetch-sequence tracker, sticky
//               error flag and retired-fetch counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_reg
    import mips8_pkg::*;
#(
    parameter int REGBITS = 3,
    parameter int CNTW    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         irwrite,
    input  logic [7:0]         memdata,
    output logic [31:0]        instr,
    output logic [5:0]         op,
    output logic [5:0]         funct,
    output logic [REGBITS-1:0] rs,
    output logic [REGBITS-1:0] rt,
    output logic [REGBITS-1:0] rd,
    output logic [15:0]        imm,
    output logic               instr_valid,
    output logic               fetch_err,
    output logic [CNTW-1:0]    fetch_count
);

    logic [31:0]     w_instr;
    logic            w_any;
    logic            w_single;
    logic [1:0]      w_lane;

    fetch_state_t    r_state;
    logic            r_valid;
    logic            r_err;
    logic [CNTW-1:0] r_count;

    // Byte capture is independent of the tracker: every flagged lane loads.
    generate
        for (genvar k = 0; k < NLANES; k++) begin : g_lane
            localparam int LO = lane_lo(k);
            ir_lane u_lane (
                .clk   (clk),
                .reset (reset),
                .en    (irwrite[k]),
                .d     (memdata),
                .q     (w_instr[LO +: 8])
            );
        end
    endgenerate

    assign w_any    = (irwrite != 4'b0000);
    assign w_single = w_any && ((irwrite & (irwrite - 4'd1)) == 4'b0000);

    always_comb begin
        w_lane = 2'd0;
        case (irwrite)
            4'b0010: w_lane = 2'd1;
            4'b0100: w_lane = 2'd2;
            4'b1000: w_lane = 2'd3;
            default: w_lane = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else if (w_any) begin
            if (!w_single) begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_err   <= 1'b1;
            end else if (w_lane == 2'd0) begin
                // Lane 0 restarts a fetch from any point without error.
                r_state <= L1;
                r_valid <= 1'b0;
            end else if ((w_lane == 2'd3) && (r_state == L3)) begin
                r_state <= IDLE;
                r_valid <= 1'b1;
                r_count <= r_count + {{(CNTW-1){1'b0}}, 1'b1};
            end else if (w_lane == 2'(r_state)) begin
                r_state <= fetch_state_t'(w_lane + 2'd1);
            end else begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_err   <= 1'b1;
            end
        end
    end

    assign instr       = w_instr;
    assign op          = w_instr[OP_HI:OP_LO];
    assign funct       = w_instr[FUNCT_HI:FUNCT_LO];
    assign rs          = w_instr[RS_LO +: REGBITS];
    assign rt          = w_instr[RT_LO +: REGBITS];
    assign rd          = w_instr[RD_LO +: REGBITS];
    assign imm         = w_instr[IMM_HI:IMM_LO];
    assign instr_valid = r_valid;
    assign fetch_err   = r_err;
    assign fetch_count = r_count;

endmodule

`default_nettype wire
